// File: rtl/vid_timing_pkg.sv
// Video mode table and geometry helpers shared by the multi-mode timing generator.
// Sync polarity fields: 1 = sync pulse is driven high, 0 = sync pulse is driven low.
package vid_timing_pkg;

    localparam int MODE_W = 12;

    typedef logic [MODE_W-1:0] mdim_t;

    typedef struct packed {
        mdim_t h_res;
        mdim_t h_fp;
        mdim_t h_sync;
        mdim_t h_bp;
        mdim_t v_res;
        mdim_t v_fp;
        mdim_t v_sync;
        mdim_t v_bp;
        logic  h_pol;
        logic  v_pol;
    } vid_mode_t;

    function automatic vid_mode_t mk_mode(input int hr, input int hf, input int hs, input int hb,
                                          input int vr, input int vf, input int vs, input int vb,
                                          input logic hp, input logic vp);
        vid_mode_t m;
        m.h_res  = MODE_W'(hr);
        m.h_fp   = MODE_W'(hf);
        m.h_sync = MODE_W'(hs);
        m.h_bp   = MODE_W'(hb);
        m.v_res  = MODE_W'(vr);
        m.v_fp   = MODE_W'(vf);
        m.v_sync = MODE_W'(vs);
        m.v_bp   = MODE_W'(vb);
        m.h_pol  = hp;
        m.v_pol  = vp;
        return m;
    endfunction

    function automatic mdim_t h_total(input vid_mode_t m);
        return m.h_res + m.h_fp + m.h_sync + m.h_bp;
    endfunction

    function automatic mdim_t v_total(input vid_mode_t m);
        return m.v_res + m.v_fp + m.v_sync + m.v_bp;
    endfunction

    function automatic mdim_t h_sync_beg(input vid_mode_t m);
        return m.h_res + m.h_fp;
    endfunction

    function automatic mdim_t h_sync_end(input vid_mode_t m);
        return m.h_res + m.h_fp + m.h_sync;
    endfunction

    function automatic mdim_t v_sync_beg(input vid_mode_t m);
        return m.v_res + m.v_fp;
    endfunction

    function automatic mdim_t v_sync_end(input vid_mode_t m);
        return m.v_res + m.v_fp + m.v_sync;
    endfunction

    // Physical sync level for a given assertion state and polarity.
    function automatic logic sync_lvl(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

    // 0: 640x480 (neg/neg), 1: 320x240 (neg/neg), 2: 1280x720 (pos/pos), 3: 800x600 (pos/pos)
    localparam vid_mode_t [0:3] VID_MODES = '{
        mk_mode( 640,  32, 88,  32, 480, 10, 5, 10, 1'b0, 1'b0),
        mk_mode( 320,  16, 44,  16, 240,  5, 3,  5, 1'b0, 1'b0),
        mk_mode(1280, 110, 40, 220, 720,  5, 5, 20, 1'b1, 1'b1),
        mk_mode( 800,  40, 128, 88, 600,  1, 4, 23, 1'b1, 1'b1)
    };

endpackage

// File: rtl/vid_delay_line.sv
// Purpose: W-bit shift register of DEPTH stages with synchronous clear to a supplied value.
// Latency: DEPTH cycles; DEPTH=0 is a combinational pass-through.
// Backpressure: none, advances every cycle.
module vid_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         p_clk_x1,
    input  logic         clr,
    input  logic [W-1:0] clr_dat,
    input  logic [W-1:0] in_dat,
    output logic [W-1:0] out_dat
);

    generate
        if (DEPTH == 0) begin : g_comb
            logic unused_ok;
            assign unused_ok = ^{p_clk_x1, clr, clr_dat};
            assign out_dat   = in_dat;
        end else begin : g_pipe
            logic [W-1:0] pipe [DEPTH];

            always_ff @(posedge p_clk_x1) begin
                if (clr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe[i] <= clr_dat;
                    end
                end else begin
                    pipe[0] <= in_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign out_dat = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vid_timing_gen_multi.sv
// Purpose: run-time selectable video timing: lookahead counters, delayed strobes, line preload.
// Latency: HPos/VPos/frame_start/preload undelayed; active/h_sync/v_sync LATENCY cycles behind.
// Backpressure: none; free-running on the pixel clock, enable low idles at (0,0).
module vid_timing_gen_multi
    import vid_timing_pkg::*;
#(
    parameter int              NUM_MODES = 2,
    parameter int              LATENCY   = 1,
    parameter int              POS_W     = 11,
    parameter vid_mode_t [0:3] MODE_TBL  = VID_MODES
) (
    input  logic             p_clk_x1,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode_sel,
    output logic [POS_W-1:0] HPos,
    output logic [POS_W-1:0] VPos,
    output logic             active,
    output logic             h_sync,
    output logic             v_sync,
    output logic             preload_vid_line,
    output logic [POS_W-1:0] preload_line,
    output logic             frame_start,
    output logic [1:0]       mode_cur,
    output logic             mode_err
);

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [2:0]       NMODES  = 3'(NUM_MODES);

    logic [POS_W-1:0] h_cnt;
    logic [POS_W-1:0] v_cnt;
    logic [1:0]       mode_q;
    logic             err_q;

    vid_mode_t        cur;
    logic [POS_W-1:0] h_res, h_last, hs_beg, hs_end;
    logic [POS_W-1:0] v_res, v_last, vs_beg, vs_end;

    assign cur    = MODE_TBL[mode_q];
    assign h_res  = POS_W'(cur.h_res);
    assign h_last = POS_W'(h_total(cur) - mdim_t'(1));
    assign hs_beg = POS_W'(h_sync_beg(cur));
    assign hs_end = POS_W'(h_sync_end(cur));
    assign v_res  = POS_W'(cur.v_res);
    assign v_last = POS_W'(v_total(cur) - mdim_t'(1));
    assign vs_beg = POS_W'(v_sync_beg(cur));
    assign vs_end = POS_W'(v_sync_end(cur));

    logic run;
    logic at_h_last;
    logic at_v_last;
    logic take_mode;
    logic mode_ok;

    assign run       = enable & ~reset;
    assign at_h_last = (h_cnt == h_last);
    assign at_v_last = (v_cnt == v_last);
    // While idle the request is tracked continuously so the restart frame uses it.
    assign take_mode = ~enable | (at_h_last & at_v_last);
    assign mode_ok   = ({1'b0, mode_sel} < NMODES);

    always_ff @(posedge p_clk_x1) begin
        if (reset) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!enable) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (at_h_last) begin
                h_cnt <= '0;
                v_cnt <= at_v_last ? '0 : v_cnt + POS_ONE;
            end else begin
                h_cnt <= h_cnt + POS_ONE;
            end

            if (take_mode) begin
                if (mode_ok) begin
                    mode_q <= mode_sel;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    logic act_raw, hs_raw, vs_raw;
    logic idle_hpol, idle_vpol;
    logic hs_on, vs_on;

    // Reset returns to mode 0, so its idle levels must already be the mode-0 ones.
    assign idle_hpol = reset ? MODE_TBL[0].h_pol : cur.h_pol;
    assign idle_vpol = reset ? MODE_TBL[0].v_pol : cur.v_pol;

    assign hs_on   = (h_cnt >= hs_beg) && (h_cnt < hs_end);
    assign vs_on   = (v_cnt >= vs_beg) && (v_cnt < vs_end);
    assign act_raw = run && (h_cnt < h_res) && (v_cnt < v_res);
    assign hs_raw  = run ? sync_lvl(hs_on, cur.h_pol) : ~idle_hpol;
    assign vs_raw  = run ? sync_lvl(vs_on, cur.v_pol) : ~idle_vpol;

    logic [2:0] dly_out;

    vid_delay_line #(
        .W     (3),
        .DEPTH (LATENCY)
    ) u_dly (
        .p_clk_x1 (p_clk_x1),
        .clr      (reset | ~enable),
        .clr_dat  ({1'b0, ~idle_hpol, ~idle_vpol}),
        .in_dat   ({act_raw, hs_raw, vs_raw}),
        .out_dat  (dly_out)
    );

    assign {active, h_sync, v_sync} = dly_out;

    logic [POS_W-1:0] next_v;
    logic             pre_mid;

    assign next_v  = v_cnt + POS_ONE;
    assign pre_mid = (next_v < v_res);

    assign preload_vid_line = run && (h_cnt == h_res) && (pre_mid || at_v_last);
    assign preload_line     = (preload_vid_line && !at_v_last) ? next_v : '0;
    assign frame_start      = run && (h_cnt == '0) && (v_cnt == '0);

    assign HPos     = h_cnt;
    assign VPos     = v_cnt;
    assign mode_cur = mode_q;
    assign mode_err = err_q;

endmodule

// File: tb/tb_vid_timing_gen_multi.sv
// Two generators share stimulus: A uses the stock mode table with LATENCY 1, B a tiny table
// with LATENCY 3 so frame boundaries, mode switching and mode errors occur within a short run.
module tb_vid_timing_gen_multi;
    import vid_timing_pkg::*;

    localparam vid_mode_t [0:3] TBL_B = '{
        mk_mode(8, 2, 3, 2, 4, 1, 1, 1, 1'b0, 1'b0),
        mk_mode(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1),
        mk_mode(6, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1),
        mk_mode(6, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1)
    };

    logic       p_clk_x1 = 1'b0;
    logic       reset    = 1'b1;
    logic       enable   = 1'b1;
    logic [1:0] mode_sel = 2'd0;

    logic [10:0] a_hpos, a_vpos, a_pline, b_hpos, b_vpos, b_pline;
    logic        a_act, a_hs, a_vs, a_pre, a_fs, a_err, b_act, b_hs, b_vs, b_pre, b_fs, b_err;
    logic [1:0]  a_mode, b_mode;

    always #5 p_clk_x1 = ~p_clk_x1;

    vid_timing_gen_multi #(.NUM_MODES(2), .LATENCY(1), .POS_W(11)) u_dut_a (
        .p_clk_x1(p_clk_x1), .reset(reset), .enable(enable), .mode_sel(mode_sel),
        .HPos(a_hpos), .VPos(a_vpos), .active(a_act), .h_sync(a_hs), .v_sync(a_vs),
        .preload_vid_line(a_pre), .preload_line(a_pline), .frame_start(a_fs),
        .mode_cur(a_mode), .mode_err(a_err));

    vid_timing_gen_multi #(.NUM_MODES(2), .LATENCY(3), .POS_W(11), .MODE_TBL(TBL_B)) u_dut_b (
        .p_clk_x1(p_clk_x1), .reset(reset), .enable(enable), .mode_sel(mode_sel),
        .HPos(b_hpos), .VPos(b_vpos), .active(b_act), .h_sync(b_hs), .v_sync(b_vs),
        .preload_vid_line(b_pre), .preload_line(b_pline), .frame_start(b_fs),
        .mode_cur(b_mode), .mode_err(b_err));

    typedef struct packed {
        logic [10:0] hpos;
        logic [10:0] vpos;
        logic        act;
        logic        hs;
        logic        vs;
        logic        pre;
        logic [10:0] pline;
        logic        fs;
        logic [1:0]  mode;
        logic        err;
    } obs_t;

    typedef struct packed {
        int hr; int hf; int hs; int hb;
        int vr; int vf; int vs; int vb;
        bit hp; bit vp;
    } geo_t;

    obs_t obs_a, obs_b;
    assign obs_a = {a_hpos, a_vpos, a_act, a_hs, a_vs, a_pre, a_pline, a_fs, a_mode, a_err};
    assign obs_b = {b_hpos, b_vpos, b_act, b_hs, b_vs, b_pre, b_pline, b_fs, b_mode, b_err};

    int checks = 0;
    int errors = 0;

    int m_h [2];
    int m_v [2];
    int m_mode [2];
    bit m_err [2];
    logic [2:0] q0 [$];
    logic [2:0] q1 [$];

    int cyc_idx;
    int acc_act_a, acc_hsl_a, acc_pre_a, acc_fs_a, acc_pre_b, acc_fs_b;
    int first_act_a, first_act_b;

    function automatic geo_t geo(input int d, input int m);
        geo_t g;
        if (d == 0 && m == 1) g = '{320, 16, 44, 16, 240, 5, 3, 5, 1'b0, 1'b0};
        else if (d == 0)      g = '{640, 32, 88, 32, 480, 10, 5, 10, 1'b0, 1'b0};
        else if (m == 1)      g = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1};
        else                  g = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b0, 1'b0};
        return g;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, got, exp);
        end
    endtask

    task automatic setq(input int d, input logic [2:0] v);
        int lat;
        lat = (d == 0) ? 1 : 3;
        if (d == 0) q0.delete(); else q1.delete();
        repeat (lat) begin
            if (d == 0) q0.push_back(v); else q1.push_back(v);
        end
    endtask

    // Expected outputs for the current cycle; raw strobes enter the scoreboard queue here.
    task automatic check_dut(input int d, input obs_t o);
        geo_t g, g0;
        int h, v, hsb, hse, vsb, vse, vt, pl;
        bit run, act, hl, vl, ihp, ivp, pre;
        logic [2:0] dly;
        g = geo(d, m_mode[d]);
        g0 = geo(d, 0);
        h = m_h[d];
        v = m_v[d];
        run = enable && !reset;
        ihp = reset ? g0.hp : g.hp;
        ivp = reset ? g0.vp : g.vp;
        hsb = g.hr + g.hf;
        hse = hsb + g.hs;
        vsb = g.vr + g.vf;
        vse = vsb + g.vs;
        vt  = vse + g.vb;
        act = run && h < g.hr && v < g.vr;
        hl  = run ? ((h >= hsb && h < hse) ? g.hp : !g.hp) : !ihp;
        vl  = run ? ((v >= vsb && v < vse) ? g.vp : !g.vp) : !ivp;
        if (d == 0) begin q0.push_back({act, hl, vl}); dly = q0[0]; end
        else        begin q1.push_back({act, hl, vl}); dly = q1[0]; end
        pre = run && h == g.hr && (v + 1 < g.vr || v == vt - 1);
        pl  = (pre && v != vt - 1) ? v + 1 : 0;
        chk("hpos", d, o.hpos, h);
        chk("vpos", d, o.vpos, v);
        chk("active", d, o.act, dly[2]);
        chk("h_sync", d, o.hs, dly[1]);
        chk("v_sync", d, o.vs, dly[0]);
        chk("preload", d, o.pre, pre);
        chk("preload_line", d, o.pline, pl);
        chk("frame_start", d, o.fs, run && h == 0 && v == 0);
        chk("mode_cur", d, o.mode, m_mode[d]);
        chk("mode_err", d, o.err, m_err[d]);
    endtask

    task automatic upd(input int d);
        geo_t g;
        int ht, vt;
        bit take;
        g  = geo(d, m_mode[d]);
        ht = g.hr + g.hf + g.hs + g.hb;
        vt = g.vr + g.vf + g.vs + g.vb;
        if (reset) begin
            g = geo(d, 0);
            setq(d, {1'b0, !g.hp, !g.vp});
            m_h[d] = 0; m_v[d] = 0; m_mode[d] = 0; m_err[d] = 0;
        end else begin
            take = !enable || (m_h[d] == ht - 1 && m_v[d] == vt - 1);
            if (!enable) begin
                setq(d, {1'b0, !g.hp, !g.vp});
                m_h[d] = 0; m_v[d] = 0;
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                if (m_h[d] == ht - 1) begin
                    m_h[d] = 0;
                    m_v[d] = (m_v[d] == vt - 1) ? 0 : m_v[d] + 1;
                end else begin
                    m_h[d] = m_h[d] + 1;
                end
            end
            if (take) begin
                if (mode_sel < 2'd2) m_mode[d] = int'(mode_sel);
                else m_err[d] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge p_clk_x1);
        check_dut(0, obs_a);
        check_dut(1, obs_b);
        acc_act_a += int'(a_act);
        acc_hsl_a += int'(!a_hs);
        acc_pre_a += int'(a_pre);
        acc_fs_a  += int'(a_fs);
        acc_pre_b += int'(b_pre);
        acc_fs_b  += int'(b_fs);
        if (first_act_a < 0 && a_act) first_act_a = cyc_idx;
        if (first_act_b < 0 && b_act) first_act_b = cyc_idx;
        cyc_idx++;
        @(posedge p_clk_x1);
        upd(0);
        upd(1);
        #1;
    endtask

    task automatic clr_acc();
        cyc_idx = 0;
        acc_act_a = 0; acc_hsl_a = 0; acc_pre_a = 0; acc_fs_a = 0;
        acc_pre_b = 0; acc_fs_b = 0;
        first_act_a = -1; first_act_b = -1;
    endtask

    initial begin
        clr_acc();
        @(posedge p_clk_x1);
        upd(0);
        upd(1);
        #1;
        repeat (2) cycle();
        chk("rst_hpos", 0, a_hpos, 0);
        chk("rst_active", 0, a_act, 0);
        chk("rst_h_sync", 0, a_hs, 1);
        chk("rst_frame_start", 1, b_fs, 0);

        // Three full mode-0 lines on A, many small frames on B.
        reset = 1'b0;
        clr_acc();
        repeat (2376) cycle();
        chk("act_cycles_3_lines", 0, acc_act_a, 1920);
        chk("hsync_low_3_lines", 0, acc_hsl_a, 264);
        chk("preload_3_lines", 0, acc_pre_a, 3);
        chk("frame_start_count", 0, acc_fs_a, 1);
        chk("first_active_cycle", 0, first_act_a, 1);
        chk("first_active_cycle", 1, first_act_b, 3);
        chk("frame_start_count", 1, acc_fs_b, 23);
        chk("preload_count", 1, acc_pre_b, 91);

        // Mode request mid-frame on B.
        mode_sel = 2'd1;
        clr_acc();
        repeat (200) cycle();
        chk("switch_frames", 1, acc_fs_b, 4);
        chk("switch_mode", 1, b_mode, 1);
        chk("switch_mode_a_kept", 0, a_mode, 0);

        // Out-of-range request, then a legal one; error stays sticky.
        mode_sel = 2'd3;
        repeat (100) cycle();
        chk("bad_mode_err", 1, b_err, 1);
        chk("bad_mode_kept", 1, b_mode, 1);
        chk("bad_mode_a_no_err", 0, a_err, 0);
        mode_sel = 2'd0;
        repeat (60) cycle();
        chk("err_sticky", 1, b_err, 1);
        chk("back_to_mode0", 1, b_mode, 0);

        // Drop enable mid-line, then restart.
        repeat (5) cycle();
        enable = 1'b0;
        repeat (4) cycle();
        chk("idle_active", 1, b_act, 0);
        chk("idle_h_sync", 1, b_hs, 1);
        chk("idle_hpos", 0, a_hpos, 0);
        repeat (2) cycle();
        enable = 1'b1;
        #1;
        chk("restart_fs", 0, a_fs, 1);
        chk("restart_fs", 1, b_fs, 1);
        repeat (50) cycle();

        // Reset mid-frame.
        reset = 1'b1;
        cycle();
        chk("midrst_hpos", 1, b_hpos, 0);
        chk("midrst_fs", 1, b_fs, 0);
        chk("midrst_active", 1, b_act, 0);
        chk("midrst_mode", 1, b_mode, 0);
        chk("midrst_err", 1, b_err, 0);
        chk("midrst_preload", 0, a_pre, 0);
        reset = 1'b0;
        repeat (120) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
